// File: rtl/fetch_buffer_if.sv
// Bundle of fetch-queue signals: redirect/stall from the pipeline, the combinational
// instruction-memory port, and the decode-side head of the queue.
interface fetch_buffer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            stall_i;
    logic [XLEN-1:0] imem_addr_o;
    logic [31:0]     imem_rdata_i;
    logic            valid_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
    logic [CW-1:0]   count_o;

    modport master (
        input  redirect_i, redirect_pc_i, stall_i, imem_rdata_i,
        output imem_addr_o, valid_o, instr_o, pc_o, count_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, stall_i, imem_rdata_i,
        input  imem_addr_o, valid_o, instr_o, pc_o, count_o
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch queue: sequential PC generation, DEPTH-entry {instr, pc} buffer
// between imem and decode, flushed to NOPs on a taken branch/jump redirect.
module fetch_buffer #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input logic            clk,
    input logic            rst,
    fetch_buffer_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full, valid, push, pop;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        full  = (count_q == CW'(DEPTH));
        valid = (count_q != '0) && !bus.redirect_i;
        pop   = valid && !bus.stall_i;
        // A full queue may still accept a fetch when the head leaves in the same cycle.
        push  = !bus.redirect_i && (!full || pop);

        if (bus.redirect_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = bus.redirect_pc_i & ~XLEN'(3);
        end else begin
            if (push) begin
                tail_d     = tail_q + PW'(1);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // NOTE: storage has no reset; count/pointers guarantee stale entries are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= {bus.imem_rdata_i, fetch_pc_q};
        end
    end

    always_comb begin
        bus.imem_addr_o = fetch_pc_q;
        bus.valid_o     = valid;
        bus.count_o     = count_q;
        bus.instr_o     = valid ? mem_q[head_q].instr : NOP;
        bus.pc_o        = valid ? mem_q[head_q].pc : '0;
    end
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised instruction fetch queue between the program counter / instruction memory and the decode stage of the pipelined core. Generates sequential fetch addresses, buffers up to DEPTH fetched instructions with their PCs, decouples fetch from decode stalls, and squashes all buffered instructions on a taken-branch/jump redirect, inserting NOPs into decode. It replaces the single IR register and branch-squash mux in front of decode.

## Interface
- XLEN, 32: address/PC width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: first fetch address after reset.
- NOP, 32'h0000_0013: instruction presented when the queue is empty or squashed (addi x0,x0,0).

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- redirect_i  input  1  taken branch/jump from execute; flush and refetch.
- redirect_pc_i  input  XLEN  redirect target; bits [1:0] ignored (treated as 0).
- stall_i  input  1  decode not ready; head entry held.
- imem_addr_o  output  XLEN  fetch address to combinational instruction memory.
- imem_rdata_i  input  32  instruction at imem_addr_o, same cycle.
- valid_o  output  1  instr_o/pc_o hold a live instruction.
- instr_o  output  32  head instruction, or NOP when valid_o=0.
- pc_o  output  XLEN  PC of head instruction, 0 when valid_o=0.
- count_o  output  $clog2(DEPTH+1)  occupied entries.

## Operation
- State: fetch_pc register, DEPTH-entry storage of {instr, pc}, head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), occupancy count.
- imem_addr_o = fetch_pc, always (combinational from register).
- pop = valid_o & ~stall_i & ~redirect_i.
- push = ~redirect_i & (count < DEPTH | pop). On push: entry[tail] ← {imem_rdata_i, fetch_pc}; tail++; fetch_pc ← fetch_pc + 4 (XLEN-bit wrap, no carry out).
- No push: fetch_pc holds; imem_addr_o unchanged.
- count next = count + push − pop; push and pop in the same cycle with count=DEPTH legal, count stays DEPTH.
- valid_o = (count != 0) & ~redirect_i. instr_o = valid_o ? entry[head].instr : NOP. pc_o = valid_o ? entry[head].pc : 0.
- Redirect (priority over everything): same cycle valid_o=0, instr_o=NOP, no push, no pop; at the edge head=tail=0, count=0, fetch_pc ← {redirect_pc_i[XLEN-1:2], 2'b00}. Stall ignored in that cycle.
- Redirect on consecutive cycles: each one flushes; the last target wins.
- Reset (asynchronous, any time, including mid-fill or mid-redirect): fetch_pc=RESET_PC, head=tail=count=0; outputs immediately valid_o=0, instr_o=NOP, pc_o=0, count_o=0, imem_addr_o=RESET_PC. Storage contents need not be reset.

## Timing
- Fetch-to-decode latency: 1 cycle. Instruction pushed at edge N appears on instr_o in the cycle after edge N.
- First cycle after rst deasserts: imem_addr_o=RESET_PC, valid_o=0; next cycle valid_o=1, pc_o=RESET_PC.
- Unstalled steady state: one instruction per cycle, count_o stays 1, pc_o advances by 4 each cycle.
- Stalled: queue fills one entry/cycle; with count_o=DEPTH fetch stops. Stall release: pop and push the same cycle, no bubble.
- After redirect at edge N: cycle N+1 imem_addr_o=target, valid_o=0; cycle N+2 valid_o=1, pc_o=target (one-cycle squash bubble plus redirect cycle).
- Paths redirect_i → valid_o/instr_o and stall_i → push are combinational; all others registered.

## Test plan
- Reset then run unstalled, imem returns addr|0xA000_0000: valid_o rises 2nd cycle, pc_o sequence 0,4,8,12, instr_o matches, count_o=1.
- Hold stall_i=1 for 8 cycles with DEPTH=4: count_o 1,2,3,4,4,...; imem_addr_o frozen at 0x10; release → pc_o 0,4,8,12,16 consecutive, no gap, no duplicate.
- Redirect to 0x0000_0103 while count_o=3 and stall_i=1: same cycle valid_o=0, instr_o=0x13; next cycle imem_addr_o=0x100, count_o=0; then pc_o=0x100.
- Redirect on two consecutive cycles (0x200 then 0x300): only 0x300 stream appears; no 0x200 instruction reaches valid_o.
- Assert rst low mid-stream with count_o=2: outputs reset asynchronously before next edge; after release pc_o restarts at RESET_PC.
- fetch_pc at 0xFFFF_FFFC, unstalled: next fetch address 0x0000_0000, both pushed in order; repeat with DEPTH=2 and DEPTH=8 for pointer wrap.
